// File: rtl/rocket_countdown_core.sv
// Launch-sequence core for the rocket demo: button sync, 8 Hz/1 Hz enable
// generation, countdown/launch sequencer and display/tone decode.
module rocket_countdown_core #(
    parameter int unsigned TICK_DIV  = 125,
    parameter int unsigned COUNT_LEN = 30,
    parameter int unsigned SEQ_END   = 33,
    parameter int unsigned WARN_LEN  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic [5:0] seq,
    output logic [2:0] pulse,
    output logic [3:0] disp_tens,
    output logic [3:0] disp_ones,
    output logic       launch,
    output logic [3:0] note,
    output logic [1:0] state
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);
    localparam int unsigned SEQ_W = 6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_LAUNCH = 2'd2,
        S_DONE   = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         sync_q, sync_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [2:0]         ph_q, ph_d;
    logic [SEQ_W-1:0]   seq_q, seq_d;
    logic [2:0]         pulse_q, pulse_d;
    logic               launch_q, launch_d;
    logic [3:0]         note_q, note_d;
    logic               btn_evt, tick, step;
    logic [SEQ_W-1:0]   rem_d, rem_c;

    always_comb begin
        // Synchronizer holds the inverted button, so its all-zero reset value
        // reads as "pressed" and a button held through reset gives no event.
        sync_d   = {sync_q[1:0], ~btn};
        btn_evt  = sync_q[2] & ~sync_q[1];

        tick     = (div_q == DIV_W'(TICK_DIV - 1));
        step     = tick && (ph_q == 3'd7);
        div_d    = tick ? '0 : div_q + DIV_W'(1);
        ph_d     = tick ? ph_q + 3'd1 : ph_q;

        state_d  = state_q;
        seq_d    = seq_q;

        case (state_q)
            S_IDLE: begin
                if (btn_evt) begin
                    state_d = S_COUNT;
                    seq_d   = SEQ_W'(1);
                    div_d   = '0;
                    ph_d    = '0;
                end
            end
            S_COUNT: begin
                if (step) begin
                    seq_d = seq_q + SEQ_W'(1);
                    if (seq_d == SEQ_W'(COUNT_LEN + 1)) state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                if (step) begin
                    seq_d = seq_q + SEQ_W'(1);
                    if (seq_d == SEQ_W'(SEQ_END)) state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (btn_evt) begin
                    state_d = S_IDLE;
                    seq_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Registered outputs are decoded from next-state values so they line
        // up with state/seq/ph in the same cycle.
        rem_d    = (state_d == S_COUNT) ? SEQ_W'(COUNT_LEN + 1) - seq_d : '0;
        pulse_d  = ph_d;
        launch_d = (state_d == S_LAUNCH);
        note_d   = 4'd0;
        if (state_d == S_LAUNCH) begin
            note_d = 4'd3;
        end else if (state_d == S_COUNT && rem_d <= SEQ_W'(WARN_LEN) && !ph_d[2]) begin
            note_d = 4'd2;
        end else if (state_d == S_COUNT && ph_d == 3'd0) begin
            note_d = 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            sync_q   <= '0;
            div_q    <= '0;
            ph_q     <= '0;
            seq_q    <= '0;
            pulse_q  <= '0;
            launch_q <= 1'b0;
            note_q   <= '0;
        end else begin
            state_q  <= state_d;
            sync_q   <= sync_d;
            div_q    <= div_d;
            ph_q     <= ph_d;
            seq_q    <= seq_d;
            pulse_q  <= pulse_d;
            launch_q <= launch_d;
            note_q   <= note_d;
        end
    end

    // BCD digits of remaining seconds, decoded straight from the registers.
    always_comb begin
        rem_c     = (state_q == S_COUNT) ? SEQ_W'(COUNT_LEN + 1) - seq_q : '0;
        disp_tens = 4'(rem_c / SEQ_W'(10));
        disp_ones = 4'(rem_c % SEQ_W'(10));
    end

    assign seq    = seq_q;
    assign pulse  = pulse_q;
    assign launch = launch_q;
    assign note   = note_q;
    assign state  = state_q;

endmodule

// File: tb/tb_rocket_countdown_core.sv
// Directed bench for rocket_countdown_core at TICK_DIV = 4 (one step per 32 clocks).
module tb_rocket_countdown_core;

    localparam int unsigned TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic [5:0] seq;
    logic [2:0] pulse;
    logic [3:0] disp_tens, disp_ones, note;
    logic       launch;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    rocket_countdown_core #(.TICK_DIV(TICK_DIV)) dut (
        .clk(clk), .rst(rst), .btn(btn), .seq(seq), .pulse(pulse),
        .disp_tens(disp_tens), .disp_ones(disp_ones), .launch(launch),
        .note(note), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (n=%0d)", tag, obs, exp, n);
        end
    endtask

    task automatic run(input int k);
        repeat (k) @(posedge clk);
        #1;
        n += k;
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".seq"},    32'(seq),       0);
        check({tag, ".state"},  32'(state),     0);
        check({tag, ".pulse"},  32'(pulse),     0);
        check({tag, ".tens"},   32'(disp_tens), 0);
        check({tag, ".ones"},   32'(disp_ones), 0);
        check({tag, ".launch"}, 32'(launch),    0);
        check({tag, ".note"},   32'(note),      0);
    endtask

    initial begin
        #1 rst = 1'b0;
        #2 check_zero("rst");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;

        // free-running phase after release
        run(3);  check("pulse3", 32'(pulse), 0);
        run(1);  check("pulse4", 32'(pulse), 1);
        run(4);  check("pulse8", 32'(pulse), 2);
        run(4);  check("pulse12", 32'(pulse), 3);
        run(4);  check("pulse16", 32'(pulse), 4);
        check("idle.state", 32'(state), 0);

        // start: one-cycle press, acted on at the third edge
        btn = 1'b1; run(1); btn = 1'b0; run(1);
        check("start.early", 32'(state), 0);
        run(1);
        n = 0;
        check("start.state",  32'(state), 1);
        check("start.seq",    32'(seq), 1);
        check("start.tens",   32'(disp_tens), 3);
        check("start.ones",   32'(disp_ones), 0);
        check("start.note",   32'(note), 1);
        check("start.pulse",  32'(pulse), 0);
        check("start.launch", 32'(launch), 0);
        run(4);  check("n4.note", 32'(note), 0);
        run(27); check("n31.seq", 32'(seq), 1);
        run(1);
        check("n32.seq",  32'(seq), 2);
        check("n32.tens", 32'(disp_tens), 2);
        check("n32.ones", 32'(disp_ones), 9);

        // press during COUNT is ignored
        btn = 1'b1; run(1); btn = 1'b0; run(2);
        run(85);
        check("cntbtn.seq",   32'(seq), 4);
        check("cntbtn.state", 32'(state), 1);

        // warning tones
        run(648);
        check("rem6.seq",  32'(seq), 25);
        check("rem6.ones", 32'(disp_ones), 6);
        check("rem6.note", 32'(note), 1);
        run(4);  check("rem6.ph1.note", 32'(note), 0);
        run(28);
        check("rem5.seq",  32'(seq), 26);
        check("rem5.ones", 32'(disp_ones), 5);
        check("rem5.note", 32'(note), 2);
        run(12); check("rem5.ph3.note", 32'(note), 2);
        run(4);
        check("rem5.ph4.note",  32'(note), 0);
        check("rem5.ph4.pulse", 32'(pulse), 4);

        // launch and done
        run(144);
        check("launch.seq",    32'(seq), 31);
        check("launch.state",  32'(state), 2);
        check("launch.launch", 32'(launch), 1);
        check("launch.note",   32'(note), 3);
        check("launch.tens",   32'(disp_tens), 0);
        check("launch.ones",   32'(disp_ones), 0);
        run(32); check("n992.seq", 32'(seq), 32);
        run(32);
        check("done.seq",    32'(seq), 33);
        check("done.state",  32'(state), 3);
        check("done.launch", 32'(launch), 0);
        check("done.note",   32'(note), 0);
        run(100);
        check("hold.seq",   32'(seq), 33);
        check("hold.state", 32'(state), 3);

        // press in DONE returns to IDLE
        btn = 1'b1; run(1); btn = 1'b0; run(1);
        check("done.btn.early", 32'(state), 3);
        run(1);
        check("done.btn.state", 32'(state), 0);
        check("done.btn.seq",   32'(seq), 0);

        // held button: single start
        btn = 1'b1; run(3);
        check("held.state", 32'(state), 1);
        check("held.seq",   32'(seq), 1);
        run(197);
        check("held197.seq",   32'(seq), 7);
        check("held197.state", 32'(state), 1);
        btn = 1'b0;
        run(155);
        check("s12.seq",  32'(seq), 12);
        check("s12.tens", 32'(disp_tens), 1);
        check("s12.ones", 32'(disp_ones), 9);
        check("s12.note", 32'(note), 1);

        // asynchronous reset mid-sequence, button held through release
        btn = 1'b1;
        rst = 1'b0;
        #1 check_zero("midrst");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b1;
        run(10);
        check("heldrst.state", 32'(state), 0);
        btn = 1'b0; run(5);
        btn = 1'b1; run(1); btn = 1'b0; run(1);
        check("repress.early", 32'(state), 0);
        run(1);
        check("repress.state", 32'(state), 1);
        check("repress.seq",   32'(seq), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
